// File: rtl/hex_scan_driver.sv
// Scan controller for a multiplexed hex display: one nibble per slot with a dead-time gap,
// a frame-synchronous shadow value and optional leading-zero blanking.
module hex_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int SLOT_CYCLES   = 50000,
    parameter int DEAD_CYCLES   = 500,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic [3:0]              data_out,
    output logic                    digit_valid,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_start
);
    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {DEAD, ON} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [3:0]              data_q, data_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    valid_q, valid_d;
    logic                    fs_q, fs_d;
    logic                    slot_end, wrap, blank;

    function automatic logic [IDX_W-1:0] top_digit(input logic [4*NUM_DIGITS-1:0] v);
        logic [IDX_W-1:0] t;
        t = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (v[4*k +: 4] != 4'h0) t = IDX_W'(k);
        end
        return t;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= DEAD;
            slot_cnt_q <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            data_q     <= 4'h0;
            anode_q    <= '1;
            valid_q    <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            data_q     <= data_d;
            anode_q    <= anode_d;
            valid_q    <= valid_d;
            fs_q       <= fs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;

        slot_end = (slot_cnt_q == SLOT_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);

        if (slot_end) begin
            slot_cnt_d = '0;
            idx_d      = wrap ? '0 : idx_q + 1'b1;
        end

        case (state_q)
            DEAD: if (slot_cnt_q == DEAD_LAST) state_d = ON;
            ON:   if (slot_end) state_d = DEAD;
            default: state_d = DEAD;
        endcase

        if (load) begin
            pending_d  = value_in;
            pend_vld_d = 1'b1;
        end
        // A load landing on the wrap cycle bypasses pending so the new frame shows it.
        if (wrap) begin
            if (load) begin
                shadow_d = value_in;
            end else if (pend_vld_q) begin
                shadow_d = pending_q;
            end
            pend_vld_d = 1'b0;
        end

        // Outputs are derived from next-cycle state so they line up with the FSM.
        blank   = BLANK_LEADING && (idx_d > top_digit(shadow_d));
        data_d  = shadow_d[{idx_d, 2'b00} +: 4];
        valid_d = (state_d == ON) && !blank;
        anode_d = valid_d ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        fs_d    = wrap;
    end

    assign data_out    = data_q;
    assign digit_valid = valid_q;
    assign anode_n     = anode_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with 4 digits, 8-cycle slots and 2 dead cycles;
// a second instance runs without leading-zero blanking.
module tb_hex_scan_driver;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [3:0]  data_a, data_b, an_a, an_b;
    logic        dv_a, dv_b, fs_a, fs_b;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    hex_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .DEAD_CYCLES(2), .BLANK_LEADING(1'b1)) dut_a (
        .CLK(CLK), .RESET(RESET), .value_in(value_in), .load(load),
        .data_out(data_a), .digit_valid(dv_a), .anode_n(an_a), .frame_start(fs_a));

    hex_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .DEAD_CYCLES(2), .BLANK_LEADING(1'b0)) dut_b (
        .CLK(CLK), .RESET(RESET), .value_in(value_in), .load(load),
        .data_out(data_b), .digit_valid(dv_b), .anode_n(an_b), .frame_start(fs_b));

    always #5 CLK = ~CLK;

    // Bench-side cycle count since the last reset edge; cyc%32 is the frame phase.
    always @(posedge CLK) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            vectors++;
            if ($countones(~an_a) > 1 || $countones(~an_b) > 1) begin
                miscompares++;
                $display("FAIL one_cold cyc=%0d an_a=%b an_b=%b required at most one low", cyc, an_a, an_b);
            end
            vectors++;
            if ((cyc % 8) < 2 && (an_a !== 4'hF || an_b !== 4'hF)) begin
                miscompares++;
                $display("FAIL dead_time cyc=%0d an_a=%b an_b=%b required 1111", cyc, an_a, an_b);
            end
            vectors++;
            if (dv_a !== (an_a != 4'hF) || dv_b !== (an_b != 4'hF)) begin
                miscompares++;
                $display("FAIL valid_vs_anode cyc=%0d dv_a=%b an_a=%b dv_b=%b an_b=%b", cyc, dv_a, an_a, dv_b, an_b);
            end
        end
    end

    task automatic advance(input int n);
        repeat (n) begin
            @(negedge CLK);
            load = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [3:0] one, ea, eb;
        int ph, slot, c;
        one = 4'b0001;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        vectors++;
        if (an_a !== 4'hF || data_a !== 4'h0 || dv_a !== 1'b0 || fs_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_a an=%b data=%h dv=%b fs=%b required 1111/0/0/0", an_a, data_a, dv_a, fs_a);
        end
        vectors++;
        if (an_b !== 4'hF || data_b !== 4'h0 || dv_b !== 1'b0 || fs_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_b an=%b data=%h dv=%b fs=%b required 1111/0/0/0", an_b, data_b, dv_b, fs_b);
        end
        for (int i = 1; i <= 32; i++) begin
            @(negedge CLK);
            ph = i % 32; slot = ph / 8; c = ph % 8;
            ea = (c >= 2 && slot == 0) ? 4'hE : 4'hF;
            eb = (c >= 2) ? ~(one << slot) : 4'hF;
            vectors++;
            if (an_a !== ea || data_a !== 4'h0 || fs_a !== (ph == 0)) begin
                miscompares++;
                $display("FAIL idle_blank ph=%0d an=%b data=%h fs=%b required %b/0/%b", ph, an_a, data_a, fs_a, ea, ph == 0);
            end
            vectors++;
            if (an_b !== eb || data_b !== 4'h0 || fs_b !== (ph == 0)) begin
                miscompares++;
                $display("FAIL idle_noblank ph=%0d an=%b data=%h fs=%b required %b/0/%b", ph, an_b, data_b, fs_b, eb, ph == 0);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        logic [3:0] nib [4];
        logic [3:0] an  [4];
        logic [3:0] ea;
        int slot, c;
        nib = '{4'h4, 4'hA, 4'h2, 4'h1};
        an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        advance(10);
        value_in = 16'h12A4;
        load = 1'b1;
        for (int i = 11; i <= 31; i++) begin
            @(negedge CLK);
            load = 1'b0;
            vectors++;
            if (an_a !== 4'hF || data_a !== 4'h0 || fs_a !== 1'b0) begin
                miscompares++;
                $display("FAIL no_tearing ph=%0d an=%b data=%h fs=%b required 1111/0/0", i, an_a, data_a, fs_a);
            end
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            slot = i / 8; c = i % 8;
            ea = (c >= 2) ? an[slot] : 4'hF;
            vectors++;
            if (data_a !== nib[slot] || an_a !== ea || fs_a !== (i == 0)) begin
                miscompares++;
                $display("FAIL show_12A4 ph=%0d data=%h an=%b fs=%b required %h/%b/%b", i, data_a, an_a, fs_a, nib[slot], ea, i == 0);
            end
            vectors++;
            if (data_b !== nib[slot] || an_b !== ea) begin
                miscompares++;
                $display("FAIL show_12A4_b ph=%0d data=%h an=%b required %h/%b", i, data_b, an_b, nib[slot], ea);
            end
        end
    endtask

    task automatic test_blank_leading();
        logic [3:0] nib [4];
        logic [3:0] an  [4];
        logic       lit [4];
        logic [3:0] ea, eb;
        int slot, c;
        nib = '{4'h0, 4'hF, 4'h0, 4'h0};
        an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        lit = '{1'b1, 1'b1, 1'b0, 1'b0};
        advance(5);
        value_in = 16'h00F0;
        load = 1'b1;
        advance(27);
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            slot = i / 8; c = i % 8;
            ea = (c >= 2 && lit[slot]) ? an[slot] : 4'hF;
            eb = (c >= 2) ? an[slot] : 4'hF;
            vectors++;
            if (data_a !== nib[slot] || an_a !== ea || dv_a !== (c >= 2 && lit[slot])) begin
                miscompares++;
                $display("FAIL blank_00F0 ph=%0d data=%h an=%b dv=%b required %h/%b/%b", i, data_a, an_a, dv_a, nib[slot], ea, c >= 2 && lit[slot]);
            end
            vectors++;
            if (data_b !== nib[slot] || an_b !== eb) begin
                miscompares++;
                $display("FAIL noblank_00F0 ph=%0d data=%h an=%b required %h/%b", i, data_b, an_b, nib[slot], eb);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] one, ea;
        int slot, c;
        one = 4'b0001;
        advance(4);
        value_in = 16'h1111;
        load = 1'b1;
        advance(17);
        value_in = 16'h2222;
        load = 1'b1;
        advance(11);
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            slot = i / 8; c = i % 8;
            ea = (c >= 2) ? ~(one << slot) : 4'hF;
            vectors++;
            if (data_a !== 4'h2 || an_a !== ea || fs_a !== (i == 0)) begin
                miscompares++;
                $display("FAIL last_wins ph=%0d data=%h an=%b fs=%b required 2/%b/%b", i, data_a, an_a, fs_a, ea, i == 0);
            end
            if (i == 31) begin
                value_in = 16'h3333;
                load = 1'b1;
            end
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            load = 1'b0;
            slot = i / 8; c = i % 8;
            ea = (c >= 2) ? ~(one << slot) : 4'hF;
            vectors++;
            if (data_a !== 4'h3 || an_a !== ea || fs_a !== (i == 0)) begin
                miscompares++;
                $display("FAIL wrap_load ph=%0d data=%h an=%b fs=%b required 3/%b/%b", i, data_a, an_a, fs_a, ea, i == 0);
            end
        end
    endtask

    task automatic test_reset_mid_on();
        logic [3:0] one, ea, eb;
        int ph, slot, c;
        one = 4'b0001;
        advance(4);
        value_in = 16'h5678;
        load = 1'b1;
        advance(9);
        vectors++;
        if (an_a !== 4'hD || data_a !== 4'h3) begin
            miscompares++;
            $display("FAIL pre_reset an=%b data=%h required 1101/3", an_a, data_a);
        end
        RESET = 1'b1;
        @(negedge CLK);
        vectors++;
        if (an_a !== 4'hF || data_a !== 4'h0 || dv_a !== 1'b0 || fs_a !== 1'b0 ||
            an_b !== 4'hF || data_b !== 4'h0 || dv_b !== 1'b0 || fs_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_on an=%b/%b data=%h/%h dv=%b/%b fs=%b/%b required 1111/0/0/0",
                     an_a, an_b, data_a, data_b, dv_a, dv_b, fs_a, fs_b);
        end
        RESET = 1'b0;
        for (int i = 1; i < 64; i++) begin
            @(negedge CLK);
            ph = i % 32; slot = ph / 8; c = ph % 8;
            ea = (c >= 2 && slot == 0) ? 4'hE : 4'hF;
            eb = (c >= 2) ? ~(one << slot) : 4'hF;
            vectors++;
            if (data_a !== 4'h0 || an_a !== ea || fs_a !== (ph == 0) || data_b !== 4'h0 || an_b !== eb) begin
                miscompares++;
                $display("FAIL pending_discarded i=%0d data=%h/%h an=%b/%b fs=%b required 0/0 %b/%b %b",
                         i, data_a, data_b, an_a, an_b, fs_a, ea, eb, ph == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_mid_frame();
        test_blank_leading();
        test_back_to_back();
        test_reset_mid_on();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
